// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - trigger-to-level pulse stretcher with optional retrigger and holdoff gap
module pulse_stretch #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned HOLDOFF = 0,
  parameter bit          RETRIG  = 1'b0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             PULSE,
  input  logic [WIDTH-1:0] LENGTH,
  output logic             LONG_SIGNAL,
  output logic             BUSY,
  output logic             OVERRUN
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] HOLD_CNT = WIDTH'(HOLDOFF);
  localparam bit               HAS_GAP  = (HOLDOFF != 0);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_len;
  logic             overrun_next;

  // a zero length still produces a single-cycle pulse
  assign load_len = (LENGTH == '0) ? CNT_ONE : LENGTH;

  assign BUSY = (state != IDLE);

  always_comb begin
    state_next   = state;
    count_next   = count;
    overrun_next = 1'b0;
    case (state)
      IDLE: begin
        if (PULSE) begin
          state_next = HIGH;
          count_next = load_len;
        end
      end
      HIGH: begin
        if (PULSE && RETRIG) begin
          count_next = load_len;
        end else begin
          overrun_next = PULSE;
          if (count <= CNT_ONE) begin
            if (HAS_GAP) begin
              state_next = GAP;
              count_next = HOLD_CNT;
            end else begin
              state_next = IDLE;
              count_next = '0;
            end
          end else begin
            count_next = count - CNT_ONE;
          end
        end
      end
      GAP: begin
        overrun_next = PULSE;
        if (count <= CNT_ONE) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      count       <= '0;
      LONG_SIGNAL <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      LONG_SIGNAL <= (state_next == HIGH);
      OVERRUN     <= overrun_next;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - self-checking bench for pulse_stretch in default, retrigger and holdoff builds
module tb_pulse_stretch;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        PULSE;
  logic [15:0] LENGTH;
  logic [2:0]  long_s;
  logic [2:0]  busy_s;
  logic [2:0]  ovr_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] rec_long [0:199];
  logic [2:0] rec_busy [0:199];
  logic [2:0] rec_ovr  [0:199];

  always #5 CLOCK = ~CLOCK;

  // index 0: defaults, 1: retriggerable, 2: holdoff of 3
  pulse_stretch #(.WIDTH(16), .HOLDOFF(0), .RETRIG(1'b0)) dut_d (
    .CLOCK(CLOCK), .RESET(RESET), .PULSE(PULSE), .LENGTH(LENGTH),
    .LONG_SIGNAL(long_s[0]), .BUSY(busy_s[0]), .OVERRUN(ovr_s[0]));
  pulse_stretch #(.WIDTH(16), .HOLDOFF(0), .RETRIG(1'b1)) dut_r (
    .CLOCK(CLOCK), .RESET(RESET), .PULSE(PULSE), .LENGTH(LENGTH),
    .LONG_SIGNAL(long_s[1]), .BUSY(busy_s[1]), .OVERRUN(ovr_s[1]));
  pulse_stretch #(.WIDTH(16), .HOLDOFF(3), .RETRIG(1'b0)) dut_h (
    .CLOCK(CLOCK), .RESET(RESET), .PULSE(PULSE), .LENGTH(LENGTH),
    .LONG_SIGNAL(long_s[2]), .BUSY(busy_s[2]), .OVERRUN(ovr_s[2]));

  function automatic logic win(input int c, input int a, input int b);
    return (c >= a) && (c <= b);
  endfunction

  function automatic logic [2:0] got(input int c, input int k);
    return {rec_ovr[c][k], rec_busy[c][k], rec_long[c][k]};
  endfunction

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    PULSE = 1'b1;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
    PULSE = 1'b0;
  endtask

  // cycle 0 is the first cycle after reset; rec[c] holds outputs seen during cycle c
  task automatic run_seq(input int n, input logic [15:0] len, input int p0, input int p1,
                         input int p2, input int rst_at);
    do_reset();
    LENGTH = len;
    rec_long[0] = long_s;
    rec_busy[0] = busy_s;
    rec_ovr[0]  = ovr_s;
    for (int c = 0; c < n; c++) begin
      PULSE = (c == p0) || (c == p1) || (c == p2);
      RESET = (c == rst_at);
      @(posedge CLOCK);
      #1;
      rec_long[c+1] = long_s;
      rec_busy[c+1] = busy_s;
      rec_ovr[c+1]  = ovr_s;
      @(negedge CLOCK);
    end
    PULSE = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLOCK);
    RESET  = 1'b1;
    PULSE  = 1'b1;
    LENGTH = 16'd5;
    @(posedge CLOCK);
    #1;
    n_checks++;
    if ({ovr_s, busy_s, long_s} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state got %b exp %b", {ovr_s, busy_s, long_s}, 9'b0);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    PULSE = 1'b0;
    @(posedge CLOCK);
    #1;
    n_checks++;
    if ({ovr_s, busy_s, long_s} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_discards_pulse got %b exp %b", {ovr_s, busy_s, long_s}, 9'b0);
    end
  endtask

  task automatic test_basic();
    logic [2:0] e;
    run_seq(30, 16'd5, 10, -1, -1, -1);
    for (int c = 0; c <= 30; c++) begin
      e = {1'b0, win(c, 11, 15), win(c, 11, 15)};
      n_checks++;
      if (got(c, 0) !== e) begin
        n_fail++;
        $display("FAIL basic_dflt c=%0d got %b exp %b", c, got(c, 0), e);
      end
      e = {1'b0, win(c, 11, 18), win(c, 11, 15)};
      n_checks++;
      if (got(c, 2) !== e) begin
        n_fail++;
        $display("FAIL basic_hold c=%0d got %b exp %b", c, got(c, 2), e);
      end
    end
  endtask

  task automatic test_len_zero();
    logic [2:0] e;
    run_seq(20, 16'd0, 10, -1, -1, -1);
    for (int c = 0; c <= 20; c++) begin
      e = {1'b0, win(c, 11, 11), win(c, 11, 11)};
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (got(c, k) !== e) begin
          n_fail++;
          $display("FAIL len_zero dut=%0d c=%0d got %b exp %b", k, c, got(c, k), e);
        end
      end
    end
  endtask

  task automatic test_nonretrig();
    logic [2:0] e;
    run_seq(35, 16'd8, 10, 13, 19, -1);
    for (int c = 0; c <= 35; c++) begin
      e = {c == 14, win(c, 11, 18) | win(c, 20, 27), win(c, 11, 18) | win(c, 20, 27)};
      n_checks++;
      if (got(c, 0) !== e) begin
        n_fail++;
        $display("FAIL nonretrig_dflt c=%0d got %b exp %b", c, got(c, 0), e);
      end
      e = {1'b0, win(c, 11, 27), win(c, 11, 27)};
      n_checks++;
      if (got(c, 1) !== e) begin
        n_fail++;
        $display("FAIL nonretrig_on_retrig c=%0d got %b exp %b", c, got(c, 1), e);
      end
    end
  endtask

  task automatic test_retrig();
    logic [2:0] e;
    run_seq(30, 16'd4, 10, 12, 16, -1);
    for (int c = 0; c <= 30; c++) begin
      e = {1'b0, win(c, 11, 20), win(c, 11, 20)};
      n_checks++;
      if (got(c, 1) !== e) begin
        n_fail++;
        $display("FAIL retrig c=%0d got %b exp %b", c, got(c, 1), e);
      end
      e = {c == 13, win(c, 11, 14) | win(c, 17, 20), win(c, 11, 14) | win(c, 17, 20)};
      n_checks++;
      if (got(c, 0) !== e) begin
        n_fail++;
        $display("FAIL retrig_on_dflt c=%0d got %b exp %b", c, got(c, 0), e);
      end
    end
  endtask

  task automatic test_holdoff();
    logic [2:0] e;
    run_seq(30, 16'd2, 10, 13, 16, -1);
    for (int c = 0; c <= 30; c++) begin
      e = {c == 14, win(c, 11, 15) | win(c, 17, 21), win(c, 11, 12) | win(c, 17, 18)};
      n_checks++;
      if (got(c, 2) !== e) begin
        n_fail++;
        $display("FAIL holdoff c=%0d got %b exp %b", c, got(c, 2), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    run_seq(170, 16'd100, 10, 52, -1, 50);
    for (int c = 0; c <= 170; c++) begin
      e = {1'b0, win(c, 11, 50) | win(c, 53, 152), win(c, 11, 50) | win(c, 53, 152)};
      n_checks++;
      if (got(c, 0) !== e) begin
        n_fail++;
        $display("FAIL reset_mid_dflt c=%0d got %b exp %b", c, got(c, 0), e);
      end
      e = {1'b0, win(c, 11, 50) | win(c, 53, 155), win(c, 11, 50) | win(c, 53, 152)};
      n_checks++;
      if (got(c, 2) !== e) begin
        n_fail++;
        $display("FAIL reset_mid_hold c=%0d got %b exp %b", c, got(c, 2), e);
      end
    end
  endtask

  // timeline model: each build tracks the last cycle of its high window and of its busy window
  task automatic test_random();
    int         hi [3];
    int         gp [3];
    logic       ov [3];
    logic [2:0] e;
    logic [2:0] g;
    int         len_eff;
    int         hold;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      hi[k] = -1;
      gp[k] = -1;
      ov[k] = 1'b0;
    end
    for (int t = 0; t < 3000; t++) begin
      PULSE   = ($urandom_range(0, 2) == 0);
      RESET   = ($urandom_range(0, 199) == 0);
      LENGTH  = 16'($urandom_range(0, 6));
      len_eff = (LENGTH == 16'd0) ? 1 : int'(LENGTH);
      for (int k = 0; k < 3; k++) begin
        hold  = (k == 2) ? 3 : 0;
        ov[k] = 1'b0;
        if (RESET) begin
          hi[k] = -1;
          gp[k] = -1;
        end else if (t <= hi[k]) begin
          if (PULSE && k == 1) begin
            hi[k] = t + len_eff;
            gp[k] = hi[k] + hold;
          end else if (PULSE) begin
            ov[k] = 1'b1;
          end
        end else if (t <= gp[k]) begin
          ov[k] = PULSE;
        end else if (PULSE) begin
          hi[k] = t + len_eff;
          gp[k] = hi[k] + hold;
        end
      end
      @(posedge CLOCK);
      #1;
      for (int k = 0; k < 3; k++) begin
        e = {ov[k], (t + 1 <= gp[k]), (t + 1 <= hi[k])};
        g = {ovr_s[k], busy_s[k], long_s[k]};
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL random dut=%0d t=%0d got %b exp %b", k, t, g, e);
        end
      end
      @(negedge CLOCK);
    end
    PULSE = 1'b0;
    RESET = 1'b0;
  endtask

  initial begin
    RESET  = 1'b1;
    PULSE  = 1'b0;
    LENGTH = 16'd0;
    test_reset();
    test_basic();
    test_len_zero();
    test_nonretrig();
    test_retrig();
    test_holdoff();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter WIDTH, default 16: bit width of LENGTH and of the internal down-counter.
REQ-002 Parameter HOLDOFF, default 0: forced low cycles after each stretched pulse; range 0..2^WIDTH-1.
REQ-003 Parameter RETRIG, default 0: 1 = retriggerable, 0 = non-retriggerable.
REQ-004 CLOCK  in  1  sole clock; all logic on the rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 PULSE  in  1  trigger; every CLOCK cycle with PULSE=1 is one trigger event.
REQ-007 LENGTH  in  WIDTH  stretched high time in cycles; sampled only on an accepted trigger.
REQ-008 LONG_SIGNAL  out  1  stretched output level, registered.
REQ-009 BUSY  out  1  high whenever state is not IDLE.
REQ-010 OVERRUN  out  1  one-cycle registered flag: a trigger was rejected.

Function
REQ-011 FSM states: IDLE, HIGH, GAP; state register, counter, LONG_SIGNAL and OVERRUN shall all be flops.
REQ-012 IDLE + PULSE=1 in cycle t: load counter with max(LENGTH,1), go to HIGH; LONG_SIGNAL=1 from cycle t+1.
REQ-013 LENGTH=0 shall be treated as 1.
REQ-014 HIGH: decrement counter each cycle; LONG_SIGNAL high for exactly max(LENGTH,1) consecutive cycles absent retrigger.
REQ-015 HIGH, last cycle (counter=1), no accepted trigger: go to GAP with counter=HOLDOFF if HOLDOFF>0, else to IDLE; LONG_SIGNAL=0 next cycle.
REQ-016 GAP: LONG_SIGNAL=0, decrement counter; go to IDLE in the cycle after counter reaches 1, so LONG_SIGNAL is low for exactly HOLDOFF cycles in GAP.
REQ-017 RETRIG=1, PULSE=1 in HIGH (including last cycle): reload counter with max(LENGTH,1); LONG_SIGNAL stays high through max(LENGTH,1) further cycles after the trigger cycle; OVERRUN not asserted.
REQ-018 RETRIG=0, PULSE=1 in HIGH: trigger ignored, counter unaffected, OVERRUN=1 for exactly the next cycle.
REQ-019 PULSE=1 in GAP (either RETRIG): trigger ignored, OVERRUN=1 for the next cycle.
REQ-020 PULSE=1 in the IDLE cycle directly after HIGH/GAP: accepted normally; at least one low cycle between consecutive non-retriggered pulses.
REQ-021 Multi-cycle PULSE: each high cycle handled per REQ-012/017/018/019 independently (no internal edge detection).
REQ-022 BUSY shall be decoded from the state register only (no PULSE-to-BUSY combinational path).
REQ-023 Counter arithmetic: unsigned WIDTH bits, never decremented below 1 in HIGH/GAP, no wrap.

Reset
REQ-024 RESET=1 at a rising edge: next cycle state=IDLE, counter=0, LONG_SIGNAL=0, BUSY=0, OVERRUN=0.
REQ-025 RESET overrides PULSE in the same cycle; the trigger is discarded, not latched.
REQ-026 RESET mid-HIGH or mid-GAP: output drops to 0 the next cycle; first PULSE after RESET deasserts starts a fresh full-length pulse.

Verification
REQ-027 Defaults, LENGTH=5, PULSE at cycle 10 -> LONG_SIGNAL high cycles 11-15, BUSY high 11-15, OVERRUN never high.
REQ-028 LENGTH=0, single PULSE -> LONG_SIGNAL high exactly 1 cycle.
REQ-029 RETRIG=0, LENGTH=8, PULSE at 10 and 13 -> high 11-18, OVERRUN high at 14 only; PULSE at 19 -> high 20-27.
REQ-030 RETRIG=1, LENGTH=4, PULSE at 10, 12, and 16 (last high cycle of second) -> LONG_SIGNAL high continuously 11-20, no OVERRUN.
REQ-031 HOLDOFF=3, LENGTH=2, PULSE at 10, 13, 16 -> high 11-12, low 13-15 with OVERRUN at 14, BUSY high 11-15; PULSE 16 accepted, high 17-18.
REQ-032 LENGTH=100, PULSE at 10, RESET at 50 -> LONG_SIGNAL=0 from 51; PULSE at 52 with RESET low -> high 53-152.
